// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache backing-memory responder.
package cache_mem_pkg;

  localparam int unsigned CM_ADDR_W = 8;
  localparam int unsigned CM_DATA_W = 32;
  localparam int unsigned LAT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cache_mem_responder_if.sv
// Request/response bus between the cache miss path (master) and the responder (slave).
interface cache_mem_responder_if
  import cache_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = CM_ADDR_W,
  parameter int unsigned DATA_W = CM_DATA_W
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_write;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_ready;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_write, resp_rdata
  );
endinterface

// File: rtl/cache_mem_array.sv
// Backing storage: synchronous write, asynchronous read, word[i]=i at time zero.
module cache_mem_array
  import cache_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = CM_ADDR_W,
  parameter int unsigned DATA_W = CM_DATA_W,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t init_words();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  // Power-up contents come from the declaration; reset never touches the array.
  mem_t mem = init_words();

  // Commit a write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency backing-memory responder for the cache refill/write-through path.
// Optional macro CACHE_MEM_STATS_EN adds saturating rd_count/wr_count outputs.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = CM_ADDR_W,
  parameter int unsigned DATA_W  = CM_DATA_W,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_mem_responder_if.slave  bus
`ifdef CACHE_MEM_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);
  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              resp_write_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              accept, fire, consume, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    fire           = 1'b0;
    consume        = 1'b0;
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_write = resp_write_q;
    bus.resp_rdata = resp_rdata_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        fire    = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.resp_ready) begin
        consume = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset landing on the commit edge must discard the pending write.
  assign mem_we = fire && cap_write && !rst;

  cache_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cap_addr),
    .wdata (cap_wdata),
    .raddr (cap_addr),
    .rdata (mem_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cnt_q     <= LAT_W'(LATENCY - 1);
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (fire) begin
        resp_write_q <= cap_write;
        resp_rdata_q <= cap_write ? '0 : mem_rdata;
      end
      if (consume) begin
        resp_write_q <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

`ifdef CACHE_MEM_STATS_EN
  // Saturating per-type counts of accepted requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (accept) begin
      if (bus.req_write && wr_count != '1) wr_count <= wr_count + 1'b1;
      if (!bus.req_write && rd_count != '1) rd_count <= rd_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized self-checking bench for cache_mem_responder (LATENCY=4 and LATENCY=1 instances).
module tb_cache_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_write, resp_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready_m, resp_valid_m, resp_write_m;
  logic [31:0] resp_rdata_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [2][256];
  int          exp_rd [2];
  int          exp_wr [2];

  always #5 clk = ~clk;

  cache_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if4 ();
  cache_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if1 ();

  assign if4.req_valid  = req_valid & ~sel;
  assign if1.req_valid  = req_valid & sel;
  assign if4.resp_ready = resp_ready & ~sel;
  assign if1.resp_ready = resp_ready & sel;
  assign if4.req_write  = req_write;
  assign if1.req_write  = req_write;
  assign if4.req_addr   = req_addr;
  assign if1.req_addr   = req_addr;
  assign if4.req_wdata  = req_wdata;
  assign if1.req_wdata  = req_wdata;

  assign req_ready_m  = sel ? if1.req_ready  : if4.req_ready;
  assign resp_valid_m = sel ? if1.resp_valid : if4.resp_valid;
  assign resp_write_m = sel ? if1.resp_write : if4.resp_write;
  assign resp_rdata_m = sel ? if1.resp_rdata : if4.resp_rdata;

`ifdef CACHE_MEM_STATS_EN
  logic [15:0] rd4, wr4, rd1, wr1;
`endif

  cache_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(4)) u4 (
    .clk (clk), .rst (rst), .bus (if4.slave)
`ifdef CACHE_MEM_STATS_EN
    , .rd_count (rd4), .wr_count (wr4)
`endif
  );

  cache_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(1)) u1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
`ifdef CACHE_MEM_STATS_EN
    , .rd_count (rd1), .wr_count (wr1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    exp_rd[0] = 0; exp_rd[1] = 0;
    exp_wr[0] = 0; exp_wr[1] = 0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  req_ready_m,  1);
    check({tag, "_resp_valid"}, resp_valid_m, 0);
    check({tag, "_resp_write"}, resp_write_m, 0);
    check({tag, "_resp_rdata"}, resp_rdata_m, 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_MEM_STATS_EN
    check({tag, "_rd4"}, 32'(rd4), 32'(exp_rd[0]));
    check({tag, "_wr4"}, 32'(wr4), 32'(exp_wr[0]));
    check({tag, "_rd1"}, 32'(rd1), 32'(exp_rd[1]));
    check({tag, "_wr1"}, 32'(wr1), 32'(exp_wr[1]));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One complete transaction; during the hold phase an optional conflicting
  // write is presented and must be ignored, including on the drain edge.
  task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input int hold, input logic spurious);
    int          s   = sel ? 1 : 0;
    int          lat = sel ? 1 : 4;
    int          cyc;
    logic [31:0] exp;
    for (int k = 0; k < 50 && !req_ready_m; k++) tick();
    check("req_ready_wait", req_ready_m, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    if (w) exp_wr[s] = (exp_wr[s] < 65535) ? exp_wr[s] + 1 : 65535;
    else   exp_rd[s] = (exp_rd[s] < 65535) ? exp_rd[s] + 1 : 65535;
    check("busy_req_ready", req_ready_m, 0);
    cyc = 0;
    while (!resp_valid_m && cyc < 50) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat));
    exp = w ? 32'd0 : model[s][a];
    check("resp_write", resp_write_m, w);
    check("resp_rdata", resp_rdata_m, exp);
    for (int h = 0; h < hold; h++) begin
      if (spurious) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = ~d;
      end
      tick();
      check("hold_resp_valid", resp_valid_m, 1);
      check("hold_resp_rdata", resp_rdata_m, exp);
      check("hold_req_ready",  req_ready_m,  0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("drain_resp_valid", resp_valid_m, 0);
    check("drain_resp_rdata", resp_rdata_m, 0);
    check("drain_req_ready",  req_ready_m,  1);
    req_valid = 1'b0;
    if (w) model[s][a] = d;
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) model[s][i] = 32'(i);
    clear_stats();
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset4");
    sel = 1'b1;
    check_idle_outputs("reset1");
    sel = 1'b0;
    check_stats("reset");
    rst = 1'b0;

    // Basic reads, write-through acknowledge and read-after-write.
    do_req(1'b0, 8'd1,   32'd0, 0, 1'b0);
    do_req(1'b0, 8'd128, 32'd0, 0, 1'b0);
    do_req(1'b1, 8'd128, 32'd2, 0, 1'b0);
    do_req(1'b0, 8'd128, 32'd0, 0, 1'b0);

    // Backpressure with a conflicting request presented while stalled.
    do_req(1'b0, 8'd7, 32'h1234_5678, 5, 1'b1);
    do_req(1'b0, 8'd7, 32'd0, 0, 1'b0);

    // Reset two cycles into a write: write is dropped.
    for (int k = 0; k < 50 && !req_ready_m; k++) tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd5; req_wdata = 32'hDEAD;
    tick();
    req_valid = 1'b0;
    tick();
    pulse_rst();
    check_idle_outputs("rst_busy");
    check_stats("rst_busy");
    do_req(1'b0, 8'd5, 32'd0, 0, 1'b0);

    // Reset while a response is pending drops it.
    for (int k = 0; k < 50 && !req_ready_m; k++) tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd9;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 50 && !resp_valid_m; k++) tick();
    check("resp_before_rst", resp_valid_m, 1);
    pulse_rst();
    check_idle_outputs("rst_resp");

    // Stats: three reads, two writes, then reset.
    do_req(1'b0, 8'd10, 32'd0, 0, 1'b0);
    do_req(1'b1, 8'd20, 32'hA5A5_0001, 1, 1'b0);
    do_req(1'b0, 8'd11, 32'd0, 0, 1'b0);
    do_req(1'b1, 8'd21, 32'hA5A5_0002, 0, 1'b0);
    do_req(1'b0, 8'd12, 32'd0, 2, 1'b0);
    check_stats("stats");
    pulse_rst();
    check_stats("stats_rst");

    // LATENCY=1 instance: back-to-back reads of words 0..3.
    sel = 1'b1;
    for (int i = 0; i < 4; i++) do_req(1'b0, 8'(i), 32'd0, 0, 1'b0);
    sel = 1'b0;

    // Randomized mix over a small address window to exercise read-after-write.
    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 3) == 0);
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    sel = 1'b0;
    check_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
